// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared ALU op codes, LC-3 opcodes, FSM states and decode record
package alu_seq_pkg;

  localparam logic [2:0] ALU_OP_NONE = 3'd0;
  localparam logic [2:0] ALU_OP_ADD  = 3'd1;
  localparam logic [2:0] ALU_OP_AND  = 3'd2;
  localparam logic [2:0] ALU_OP_NOT  = 3'd3;

  localparam logic [3:0] OPC_ADD = 4'b0001;
  localparam logic [3:0] OPC_AND = 4'b0101;
  localparam logic [3:0] OPC_NOT = 4'b1001;

  localparam logic [2:0] NZP_RESET = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_EXEC = 3'd2,
    ST_WB   = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  typedef struct packed {
    logic        legal;
    logic [2:0]  op;
    logic [2:0]  dr;
    logic [2:0]  sr1;
    logic [2:0]  sr2;
    logic        imm_flag;
    logic [15:0] imm;
  } dec_t;

  // Exactly one of {N,Z,P} is set for any result.
  function automatic logic [2:0] nzp_of(input logic [15:0] v);
    if (v[15])
      return 3'b100;
    else if (v == 16'h0000)
      return 3'b010;
    else
      return 3'b001;
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - instruction handshake, register file and ALU signal bundle
interface alu_seq_if;

  logic        inst_valid_i_w;
  logic        inst_ready_o_r;
  logic [15:0] inst_i_w;
  logic [2:0]  rf_raddr1_o_r;
  logic [2:0]  rf_raddr2_o_r;
  logic [15:0] rf_rdata1_i_w;
  logic [15:0] rf_rdata2_i_w;
  logic        rf_we_o_r;
  logic [2:0]  rf_waddr_o_r;
  logic [15:0] rf_wdata_o_r;
  logic        alu_en_o_r;
  logic [2:0]  alu_op_o_r;
  logic [15:0] alu_s1_o_r;
  logic [15:0] alu_s2_o_r;
  logic [15:0] alu_out_i_w;
  logic [2:0]  nzp_o_r;
  logic        done_o_r;
  logic        err_o_r;

  modport master (
    input  inst_valid_i_w, inst_i_w, rf_rdata1_i_w, rf_rdata2_i_w, alu_out_i_w,
    output inst_ready_o_r, rf_raddr1_o_r, rf_raddr2_o_r, rf_we_o_r, rf_waddr_o_r,
           rf_wdata_o_r, alu_en_o_r, alu_op_o_r, alu_s1_o_r, alu_s2_o_r,
           nzp_o_r, done_o_r, err_o_r
  );

  modport slave (
    output inst_valid_i_w, inst_i_w, rf_rdata1_i_w, rf_rdata2_i_w, alu_out_i_w,
    input  inst_ready_o_r, rf_raddr1_o_r, rf_raddr2_o_r, rf_we_o_r, rf_waddr_o_r,
           rf_wdata_o_r, alu_en_o_r, alu_op_o_r, alu_s1_o_r, alu_s2_o_r,
           nzp_o_r, done_o_r, err_o_r
  );

endinterface

// File: rtl/alu_seq_dec.sv
// rtl/alu_seq_dec.sv - combinational LC-3 ALU instruction field extractor
module alu_seq_dec
  import alu_seq_pkg::*;
(
  input  logic [15:0] inst,
  output dec_t        dec
);

  always_comb begin
    dec          = '0;
    dec.dr       = inst[11:9];
    dec.sr1      = inst[8:6];
    dec.sr2      = inst[2:0];
    dec.imm_flag = inst[5];
    dec.imm      = {{11{inst[4]}}, inst[4:0]};
    case (inst[15:12])
      OPC_ADD: begin
        dec.legal = 1'b1;
        dec.op    = ALU_OP_ADD;
      end
      OPC_AND: begin
        dec.legal = 1'b1;
        dec.op    = ALU_OP_AND;
      end
      OPC_NOT: begin
        dec.legal = 1'b1;
        dec.op    = ALU_OP_NOT;
      end
      default: begin
        dec.legal = 1'b0;
        dec.op    = ALU_OP_NONE;
      end
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - execute-stage sequencer for LC-3 ADD/AND/NOT
module alu_seq
  import alu_seq_pkg::*;
(
  input  logic      clk_i_w,
  input  logic      rst_i_w,
  alu_seq_if.master bus
);

  dec_t        dec;
  state_t      state;
  logic        ready_q;
  logic [2:0]  raddr1_q;
  logic [2:0]  raddr2_q;
  logic        we_q;
  logic [2:0]  waddr_q;
  logic [15:0] wdata_q;
  logic        alu_en_q;
  logic [2:0]  alu_op_q;
  logic [2:0]  nzp_q;
  logic        done_q;
  logic        err_q;
  logic [2:0]  op_q;
  logic [2:0]  dr_q;
  logic        imm_flag_q;
  logic [15:0] imm_q;
  logic [15:0] s1;
  logic [15:0] s2;

  alu_seq_dec u_dec (
    .inst (bus.inst_i_w),
    .dec  (dec)
  );

  always_ff @(posedge clk_i_w or negedge rst_i_w) begin
    if (!rst_i_w) begin
      state      <= ST_IDLE;
      ready_q    <= 1'b1;
      raddr1_q   <= 3'd0;
      raddr2_q   <= 3'd0;
      we_q       <= 1'b0;
      waddr_q    <= 3'd0;
      wdata_q    <= 16'h0000;
      alu_en_q   <= 1'b0;
      alu_op_q   <= ALU_OP_NONE;
      nzp_q      <= NZP_RESET;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      op_q       <= ALU_OP_NONE;
      dr_q       <= 3'd0;
      imm_flag_q <= 1'b0;
      imm_q      <= 16'h0000;
    end else begin
      we_q     <= 1'b0;
      waddr_q  <= 3'd0;
      wdata_q  <= 16'h0000;
      alu_en_q <= 1'b0;
      alu_op_q <= ALU_OP_NONE;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.inst_valid_i_w && ready_q) begin
            ready_q    <= 1'b0;
            op_q       <= dec.op;
            dr_q       <= dec.dr;
            imm_flag_q <= dec.imm_flag;
            imm_q      <= dec.imm;
            if (dec.legal) begin
              state    <= ST_READ;
              raddr1_q <= dec.sr1;
              raddr2_q <= dec.sr2;
            end else begin
              state <= ST_ERR;
              err_q <= 1'b1;
            end
          end
        end
        ST_READ: begin
          // Addresses stay on the bus so the register file keeps presenting data during EXEC.
          state    <= ST_EXEC;
          alu_en_q <= 1'b1;
          alu_op_q <= op_q;
        end
        ST_EXEC: begin
          state    <= ST_WB;
          raddr1_q <= 3'd0;
          raddr2_q <= 3'd0;
          we_q     <= 1'b1;
          waddr_q  <= dr_q;
          wdata_q  <= bus.alu_out_i_w;
          done_q   <= 1'b1;
        end
        ST_WB: begin
          state   <= ST_IDLE;
          ready_q <= 1'b1;
          nzp_q   <= nzp_of(wdata_q);
        end
        ST_ERR: begin
          state   <= ST_IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state   <= ST_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Read data only arrives one cycle after the address, so operands follow it directly in EXEC.
  always_comb begin
    s1 = 16'h0000;
    s2 = 16'h0000;
    if (state == ST_EXEC) begin
      s1 = bus.rf_rdata1_i_w;
      if (op_q != ALU_OP_NOT)
        s2 = imm_flag_q ? imm_q : bus.rf_rdata2_i_w;
    end
  end

  assign bus.inst_ready_o_r = ready_q;
  assign bus.rf_raddr1_o_r  = raddr1_q;
  assign bus.rf_raddr2_o_r  = raddr2_q;
  assign bus.rf_we_o_r      = we_q;
  assign bus.rf_waddr_o_r   = waddr_q;
  assign bus.rf_wdata_o_r   = wdata_q;
  assign bus.alu_en_o_r     = alu_en_q;
  assign bus.alu_op_o_r     = alu_op_q;
  assign bus.alu_s1_o_r     = s1;
  assign bus.alu_s2_o_r     = s2;
  assign bus.nzp_o_r        = nzp_q;
  assign bus.done_o_r       = done_q;
  assign bus.err_o_r        = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed table-driven bench for alu_seq
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  alu_seq_if bus ();

  alu_seq dut (
    .clk_i_w (clk),
    .rst_i_w (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous register file with a bench-side preload port.
  logic [15:0] rf [8];
  logic        pre_we;
  logic [2:0]  pre_addr;
  logic [15:0] pre_data;
  logic [15:0] rd1, rd2;

  always @(posedge clk) begin
    if (bus.rf_we_o_r)
      rf[bus.rf_waddr_o_r] <= bus.rf_wdata_o_r;
    else if (pre_we)
      rf[pre_addr] <= pre_data;
    rd1 <= rf[bus.rf_raddr1_o_r];
    rd2 <= rf[bus.rf_raddr2_o_r];
  end

  assign bus.rf_rdata1_i_w = rd1;
  assign bus.rf_rdata2_i_w = rd2;

  always_comb begin
    bus.alu_out_i_w = 16'h0000;
    if (bus.alu_en_o_r) begin
      case (bus.alu_op_o_r)
        ALU_OP_ADD: bus.alu_out_i_w = bus.alu_s1_o_r + bus.alu_s2_o_r;
        ALU_OP_AND: bus.alu_out_i_w = bus.alu_s1_o_r & bus.alu_s2_o_r;
        ALU_OP_NOT: bus.alu_out_i_w = ~bus.alu_s1_o_r;
        default:    bus.alu_out_i_w = 16'h0000;
      endcase
    end
  end

  int xfers[$];
  int we_pulses = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.inst_valid_i_w && bus.inst_ready_o_r)
      xfers.push_back(cyc);
    if (bus.rf_we_o_r)
      we_pulses <= we_pulses + 1;
  end

  typedef struct {
    logic [2:0]  a_addr;
    logic [15:0] a_val;
    logic [2:0]  b_addr;
    logic [15:0] b_val;
    logic [15:0] inst;
    logic [2:0]  dr;
    logic [15:0] res;
    logic [2:0]  nzp;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic preload(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    pre_we = 1'b1;
    pre_addr = a;
    pre_data = d;
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  // Waits for ready, then presents one instruction for exactly one transfer edge (edge A).
  task automatic issue(input logic [15:0] inst);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.inst_ready_o_r && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("ready_timeout", 0, 1);
    bus.inst_i_w = inst;
    bus.inst_valid_i_w = 1'b1;
    @(posedge clk);
    #1 bus.inst_valid_i_w = 1'b0;
  endtask

  logic [2:0]  nzp_now;
  logic [15:0] keep;
  int          we_before;

  initial begin
    vecs[0] = '{3'd1, 16'h0003, 3'd2, 16'h0004, 16'h1042, 3'd0, 16'h0007, 3'b001};
    vecs[1] = '{3'd1, 16'h0003, 3'd2, 16'h0004, 16'h167B, 3'd3, 16'hFFFE, 3'b100};
    vecs[2] = '{3'd1, 16'h00F0, 3'd2, 16'h0F0F, 16'h5442, 3'd2, 16'h0000, 3'b010};
    vecs[3] = '{3'd5, 16'h1234, 3'd5, 16'h1234, 16'h997F, 3'd4, 16'hEDCB, 3'b100};
    vecs[4] = '{3'd1, 16'h8000, 3'd2, 16'h8000, 16'h1A42, 3'd5, 16'h0000, 3'b010};

    rst_n = 1'b0;
    bus.inst_valid_i_w = 1'b0;
    bus.inst_i_w = 16'h0000;
    pre_we = 1'b0;
    pre_addr = 3'd0;
    pre_data = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_nzp", {29'd0, bus.nzp_o_r}, 32'h2);
    chk("reset_ready", {31'd0, bus.inst_ready_o_r}, 32'h1);
    chk("reset_we", {31'd0, bus.rf_we_o_r}, 32'h0);
    chk("reset_err", {31'd0, bus.err_o_r}, 32'h0);

    for (int i = 0; i < 5; i++) begin
      preload(vecs[i].a_addr, vecs[i].a_val);
      preload(vecs[i].b_addr, vecs[i].b_val);
      issue(vecs[i].inst);
      @(negedge clk);
      chk($sformatf("v%0d_raddr1", i), {29'd0, bus.rf_raddr1_o_r}, {29'd0, vecs[i].a_addr});
      @(negedge clk);
      chk($sformatf("v%0d_alu_en", i), {31'd0, bus.alu_en_o_r}, 32'h1);
      @(negedge clk);
      chk($sformatf("v%0d_we", i), {31'd0, bus.rf_we_o_r}, 32'h1);
      chk($sformatf("v%0d_done", i), {31'd0, bus.done_o_r}, 32'h1);
      chk($sformatf("v%0d_waddr", i), {29'd0, bus.rf_waddr_o_r}, {29'd0, vecs[i].dr});
      chk($sformatf("v%0d_wdata", i), {16'd0, bus.rf_wdata_o_r}, {16'd0, vecs[i].res});
      @(negedge clk);
      chk($sformatf("v%0d_nzp", i), {29'd0, bus.nzp_o_r}, {29'd0, vecs[i].nzp});
      chk($sformatf("v%0d_ready", i), {31'd0, bus.inst_ready_o_r}, 32'h1);
      chk($sformatf("v%0d_rf", i), {16'd0, rf[vecs[i].dr]}, {16'd0, vecs[i].res});
    end

    // Illegal opcode: one ERR cycle, no write, NZP held.
    nzp_now = bus.nzp_o_r;
    we_before = we_pulses;
    issue(16'h0000);
    @(negedge clk);
    chk("err_pulse", {31'd0, bus.err_o_r}, 32'h1);
    chk("err_ready_low", {31'd0, bus.inst_ready_o_r}, 32'h0);
    @(negedge clk);
    chk("err_ready_back", {31'd0, bus.inst_ready_o_r}, 32'h1);
    chk("err_cleared", {31'd0, bus.err_o_r}, 32'h0);
    chk("err_nzp", {29'd0, bus.nzp_o_r}, {29'd0, nzp_now});
    chk("err_no_write", we_pulses, we_before);

    // Back-to-back: valid held high over three ADDs.
    preload(3'd1, 16'h0001);
    preload(3'd2, 16'h0002);
    @(negedge clk);
    xfers.delete();
    bus.inst_i_w = 16'h1042;
    bus.inst_valid_i_w = 1'b1;
    for (int n = 0; n < 30 && xfers.size() < 3; n++) @(negedge clk);
    bus.inst_valid_i_w = 1'b0;
    chk("b2b_count", xfers.size(), 3);
    if (xfers.size() >= 3) begin
      chk("b2b_gap1", xfers[1] - xfers[0], 4);
      chk("b2b_gap2", xfers[2] - xfers[1], 4);
    end
    repeat (4) @(negedge clk);
    chk("b2b_nzp", {29'd0, bus.nzp_o_r}, 32'h1);
    chk("b2b_rf", {16'd0, rf[0]}, 32'h3);

    // Reset in the middle of EXEC of a fourth instruction.
    preload(3'd6, 16'h0055);
    we_before = we_pulses;
    issue(16'h1C42);
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_exec", {31'd0, bus.alu_en_o_r}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_nzp", {29'd0, bus.nzp_o_r}, 32'h2);
    chk("rst_alu_en", {31'd0, bus.alu_en_o_r}, 32'h0);
    chk("rst_s1", {16'd0, bus.alu_s1_o_r}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", {31'd0, bus.inst_ready_o_r}, 32'h1);
    repeat (4) @(negedge clk);
    keep = rf[6];
    chk("rst_no_write_rf", {16'd0, keep}, 32'h55);
    chk("rst_no_we", we_pulses, we_before);
    chk("rst_nzp_after", {29'd0, bus.nzp_o_r}, 32'h2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
